fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 RESET_PC, 32'h0000_0000, first fetch address after reset SHALL be this value.
REQ-002 QDEPTH, 2, instruction queue depth; SHALL be a power of two, 2..8.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 fetch_en  input  1  permits new memory requests.
REQ-006 imem_req  output  1  fetch request valid.
REQ-007 imem_addr  output  32  fetch address, word aligned.
REQ-008 imem_gnt  input  1  request accepted when imem_req&imem_gnt.
REQ-009 imem_rvalid  input  1  response valid; in order; earliest one cycle after grant.
REQ-010 imem_rdata  input  32  response instruction word.
REQ-011 redirect_valid  input  1  branch/jump redirect strobe from execute.
REQ-012 redirect_pc  input  32  redirect target.
REQ-013 if_valid  output  1  queue head valid toward decoder.
REQ-014 if_ready  input  1  decoder accepts head when if_valid&if_ready.
REQ-015 if_instr  output  32  head instruction word.
REQ-016 if_pc  output  32  head instruction address.
REQ-017 if_opcode  output  7  if_instr[6:0].
REQ-018 if_funct3  output  3  if_instr[14:12].
REQ-019 if_funct7  output  7  if_instr[31:25].

Function
REQ-020 FSM states BOOT, RUN, HALT; BOOT SHALL last exactly one cycle after rst_n release, then RUN if fetch_en=1 else HALT.
REQ-021 RUN->HALT when fetch_en=0, HALT->RUN when fetch_en=1, effective next cycle; HALT issues no requests but still accepts responses.
REQ-022 imem_req=1 only in RUN, no redirect this cycle, and (queued + outstanding) < QDEPTH; imem_req/imem_addr held stable until granted.
REQ-023 Fetch PC SHALL advance by 4 on each grant; 32'hFFFF_FFFC wraps to 32'h0.
REQ-024 Each non-discarded response SHALL be pushed with its address; credit rule guarantees no overflow.
REQ-025 if_valid=1 iff queue non-empty; head outputs combinational from queue; grant-to-if_valid latency minimum 2 cycles.
REQ-026 Simultaneous push and pop SHALL be legal at any occupancy, including full and empty; occupancy unchanged.
REQ-027 redirect_valid: queue flushed (if_valid=0 next cycle), fetch PC <= {redirect_pc[31:2],2'b00}, imem_req forced 0 that cycle, new target requested from next cycle.
REQ-028 Requests outstanding at redirect SHALL load a discard counter; their responses, including one arriving in the redirect cycle, SHALL be dropped.
REQ-029 Redirect SHALL take priority over same-cycle push and pop; a pop in that cycle is not counted as delivered.
REQ-030 Redirect in HALT SHALL update fetch PC and flush; no request until RUN.
REQ-031 imem_rvalid with zero outstanding requests SHALL be ignored with no state change.

Reset
REQ-032 rst_n low SHALL immediately force BOOT, fetch PC=RESET_PC, queue empty, outstanding=0, discard=0.
REQ-033 During reset and BOOT: imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=0, if_opcode/funct3/funct7=0; late responses from pre-reset requests ignored per REQ-031.

Configuration
REQ-034 FETCH_PERF_CNT_EN defined: outputs perf_fetch_cnt (32, counts pops) and perf_flush_cnt (32, counts redirect cycles), reset 0, wrap at 2^32; undefined: ports and counters absent, all other behaviour identical.

Verification
REQ-035 fetch_en=1, gnt=1, rvalid one cycle after grant, if_ready=1 -> imem_addr 0,4,8,...; if_pc 0,4,8,... one per cycle after warm-up.
REQ-036 if_ready=0, QDEPTH=2 -> exactly 2 grants, imem_req then 0, if_pc=0 held; raise if_ready -> pcs 0,4 delivered, fetch resumes at 8.
REQ-037 Outstanding 8 and 12, redirect_pc=32'h0000_0103 -> both responses dropped, next imem_addr 32'h100, first if_pc 32'h100.
REQ-038 imem_rdata=32'h4020_8033 -> if_opcode 7'b0110011, if_funct3 3'b000, if_funct7 7'b0100000.
REQ-039 Fetch PC 32'hFFFF_FFFC -> next imem_addr 0; rst_n low mid-flight -> outputs at reset values same cycle, late rvalid ignored.
REQ-040 FETCH_PERF_CNT_EN defined, 5 pops and 1 redirect -> perf_fetch_cnt=5, perf_flush_cnt=1.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: in-order instruction fetch with a credit-limited queue toward decode.
// Defining FETCH_PERF_CNT_EN adds the perf_fetch_cnt / perf_flush_cnt counters.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [6:0]  if_opcode,
    output logic [2:0]  if_funct3,
    output logic [6:0]  if_funct7
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);

    localparam int AW = (QDEPTH > 2) ? $clog2(QDEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW:0] QDEPTH_W = (CW+1)'(QDEPTH);

    typedef enum logic [1:0] {
        ST_BOOT = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [31:0]   r_pc;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_out;
    logic [CW-1:0] r_disc;
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [31:0]   r_q_instr [QDEPTH];
    logic [31:0]   r_q_pc    [QDEPTH];

    logic          w_pop;
    logic          w_resp;
    logic          w_push;
    logic          w_grant;
    logic          w_credit;
    logic [CW:0]   w_demand;
    logic [CW-1:0] w_out_nxt;
    logic [CW-1:0] w_disc_nxt;
    logic [31:0]   w_resp_pc;

    assign if_valid  = (r_count != {CW{1'b0}});
    assign w_pop     = if_valid & if_ready & ~redirect_valid;
    assign w_resp    = imem_rvalid & (r_out != {CW{1'b0}});
    assign w_push    = w_resp & (r_disc == {CW{1'b0}}) & ~redirect_valid;
    assign w_grant   = imem_req & imem_gnt;
    // A pop this cycle frees its slot, so back-to-back delivery fits in a depth-2 queue.
    assign w_demand  = {1'b0, r_count} - (CW+1)'(w_pop) + {1'b0, r_out};
    assign w_credit  = (w_demand < QDEPTH_W);
    assign w_out_nxt = r_out + CW'(w_grant) - CW'(w_resp);
    // Live requests are consecutive words ending at the fetch PC, so the oldest one is recoverable.
    assign w_resp_pc = r_pc - {{(30-CW){1'b0}}, r_out, 2'b00};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and request decode.
    always_comb begin
        w_state_nxt = r_state;
        imem_req    = 1'b0;
        case (r_state)
            ST_BOOT: begin
                if (fetch_en) w_state_nxt = ST_RUN;
                else          w_state_nxt = ST_HALT;
            end
            ST_RUN: begin
                imem_req = ~redirect_valid & w_credit;
                if (fetch_en) w_state_nxt = ST_RUN;
                else          w_state_nxt = ST_HALT;
            end
            ST_HALT: begin
                if (fetch_en) w_state_nxt = ST_RUN;
                else          w_state_nxt = ST_HALT;
            end
            default: begin
                w_state_nxt = ST_BOOT;
            end
        endcase
    end

    // Request address; pinned to the reset vector while booting.
    always_comb begin
        if (r_state == ST_BOOT) imem_addr = RESET_PC;
        else                    imem_addr = r_pc;
    end

    // Discard count: on redirect every request still in flight becomes garbage.
    always_comb begin
        w_disc_nxt = r_disc;
        if (redirect_valid) begin
            w_disc_nxt = w_out_nxt;
        end else if (w_resp && (r_disc != {CW{1'b0}})) begin
            w_disc_nxt = r_disc - CW'(1);
        end else begin
            w_disc_nxt = r_disc;
        end
    end

    // Fetch PC and in-flight bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc   <= RESET_PC;
            r_out  <= {CW{1'b0}};
            r_disc <= {CW{1'b0}};
        end else begin
            if (redirect_valid) begin
                r_pc <= redirect_pc & 32'hFFFF_FFFC;
            end else if (w_grant) begin
                r_pc <= r_pc + 32'd4;
            end else begin
                r_pc <= r_pc;
            end
            r_out  <= w_out_nxt;
            r_disc <= w_disc_nxt;
        end
    end

    // Queue pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= {AW{1'b0}};
            r_wr_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else if (redirect_valid) begin
            r_rd_ptr <= {AW{1'b0}};
            r_wr_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Queue storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < QDEPTH; i++) begin
                r_q_instr[i] <= 32'h0000_0000;
                r_q_pc[i]    <= 32'h0000_0000;
            end
        end else if (w_push) begin
            r_q_instr[r_wr_ptr] <= imem_rdata;
            r_q_pc[r_wr_ptr]    <= w_resp_pc;
        end
    end

    // Head of queue toward decode; zero when empty.
    always_comb begin
        if (if_valid) begin
            if_instr = r_q_instr[r_rd_ptr];
            if_pc    = r_q_pc[r_rd_ptr];
        end else begin
            if_instr = 32'h0000_0000;
            if_pc    = 32'h0000_0000;
        end
    end

    assign if_opcode = if_instr[6:0];
    assign if_funct3 = if_instr[14:12];
    assign if_funct7 = if_instr[31:25];

`ifdef FETCH_PERF_CNT_EN
    // Delivered-instruction and flush counters, free-running modulo 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt <= 32'h0000_0000;
            perf_flush_cnt <= 32'h0000_0000;
        end else begin
            if (w_pop)          perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (redirect_valid) perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif

endmodule
